fifo_wr_arb: RTL
================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req0, req1  input  1 each  write request from producer 0 / producer 1.
REQ-004 SHALL have ports: din0, din1  input  8 each  write data of producer 0 / producer 1.
REQ-005 SHALL have port: ren  input  1  consumer read request.
REQ-006 SHALL have ports: gnt0, gnt1  output  1 each  write grant, combinational, one-hot or zero.
REQ-007 SHALL have port: dout  output  8  registered read data.
REQ-008 SHALL have port: dout_src  output  1  producer index that wrote the dout byte.
REQ-009 SHALL have port: dout_valid  output  1  registered; high for exactly one cycle per accepted read.
REQ-010 SHALL have port: error  output  1  registered; high for one cycle after a read with the FIFO empty.
REQ-011 SHALL have ports: count  output  4  occupancy 0..8; full, empty  output  1 each  (count==8, count==0).

Function
REQ-012 SHALL store 8 entries of 9 bits {src, data} in a circular buffer with 3-bit wptr/rptr that wrap 7->0.
REQ-013 SHALL assert no grant while full==1, even if ren is high in the same cycle; requesters simply stall, with no error.
REQ-014 SHALL, when not full and exactly one req is high, grant that requester.
REQ-015 SHALL, when not full and both reqs are high, grant the requester other than last_gnt (round-robin).
REQ-016 SHALL update last_gnt only in cycles where a grant is issued; it holds otherwise.
REQ-017 SHALL, on a clock edge with a grant, write {index, din} of the granted producer at wptr, then increment wptr.
REQ-018 SHALL, on ren with empty==0, load dout/dout_src from rptr at the next edge, increment rptr, and pulse dout_valid.
REQ-019 SHALL, on ren with empty==1, leave the pointers unchanged, set dout=0 and dout_valid=0, and pulse error.
REQ-020 SHALL, with a grant and an accepted read in the same cycle, perform both and leave count unchanged.
REQ-021 SHALL, when empty with ren high and a grant in the same cycle, flag the read error and still complete the write (count 0->1).
REQ-022 SHALL hold dout and dout_src when no read is accepted; dout_valid and error are 0 in every cycle without the respective event.
REQ-023 SHALL update count as +1 on write only, -1 on read only, else hold; count never exceeds 8 or underflows.

Reset
REQ-024 SHALL, on rst_n low, immediately set dout=0, dout_src=0, dout_valid=0, error=0, count=0, wptr=0, rptr=0, last_gnt=1.
REQ-025 SHALL force gnt0=gnt1=0 while rst_n is low.
REQ-026 SHALL discard buffer contents on reset mid-operation; storage array itself needs no reset.
REQ-027 SHALL resume operation on the first rising edge after rst_n deasserts, with producer 0 winning the first tie.

Structure
REQ-028 SHALL take DEPTH=8, DATA_W=8, PTR_W=3 and CNT_W=4 from shared package fifo_arb_pkg.
REQ-029 SHALL place grant logic plus the last_gnt register in one sub-module rr_arb2 (inputs req[1:0], en, clk, rst_n; output gnt[1:0]).
REQ-030 SHALL keep pointers, count, storage and output registers in fifo_wr_arb.

Verification
REQ-031 SHALL cover tie: reset, then req0=req1=1 for 4 cycles with din0=0xA0, din1=0xB0 -> grants 0,1,0,1; four reads return A0/0, B0/1, A0/0, B0/1.
REQ-032 SHALL cover full stall: req0=1 for 10 cycles -> 8 grants, then gnt0=0, full=1, count=8, error stays 0.
REQ-033 SHALL cover full boundary: full, then req1=1 and ren=1 together -> no grant that cycle, count=7; next cycle gnt1=1, count returns to 8.
REQ-034 SHALL cover empty read: ren=1 on empty -> error=1 and dout_valid=0 next cycle; error=0 the cycle after.
REQ-035 SHALL cover wrap: 12 writes of 0x00..0x0B interleaved with reads -> reads return 0x00..0x0B in order across pointer wrap.
REQ-036 SHALL cover async reset: assert rst_n mid-burst with count=5 -> outputs clear without a clock edge; a subsequent ren gives error=1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared sizing and entry layout for the two-producer write-arbitrated FIFO.
package fifo_arb_pkg;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int PTR_W  = 3;
  localparam int CNT_W  = 4;

  // One stored entry: producer index plus its data byte.
  typedef struct packed {
    logic              src;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Build an entry from a producer index and data byte.
  function automatic entry_t mk_entry(input logic src, input logic [DATA_W-1:0] data);
    entry_t e;
    e.src  = src;
    e.data = data;
    return e;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  // Index of the most recent winner; reset to 1 so producer 0 wins the first tie.
  logic last_q;

  // Grant is suppressed while disabled or while held in reset.
  always_comb begin
    gnt = 2'b00;
    if (rst_n && en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the winner only on cycles that actually issue a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'b1;
    else if (|gnt) last_q <= gnt[1];
  end
endmodule

// File: rtl/fifo_wr_arb.sv
// 8-entry FIFO written by two arbitrated producers, read by one consumer.
module fifo_wr_arb
  import fifo_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic              ren,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] dout,
  output logic              dout_src,
  output logic              dout_valid,
  output logic              error,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  dout_q;
  logic               dout_src_q, dout_valid_q, error_q;
  logic [1:0]         gnt;
  logic               wr, rd, rd_err;
  entry_t             wr_entry;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Arbiter is disabled when full, even if a read frees a slot this cycle.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .en    (!full),
    .gnt   (gnt)
  );

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign wr       = |gnt;
  assign rd       = ren && !empty;
  assign rd_err   = ren && empty;
  assign wr_entry = mk_entry(gnt[1], gnt[1] ? din1 : din0);

  // Occupancy: simultaneous write and read cancel out.
  always_comb begin
    count_d = count_q;
    if (wr && !rd)      count_d = count_q + 1'b1;
    else if (rd && !wr) count_d = count_q - 1'b1;
  end

  // Storage array carries no reset; stale contents are unreachable after pointer reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= wr_entry;
  end

  // Pointers, occupancy and registered read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_src_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_valid_q <= rd;
      error_q      <= rd_err;
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) begin
        rptr_q     <= rptr_q + 1'b1;
        dout_q     <= mem[rptr_q].data;
        dout_src_q <= mem[rptr_q].src;
      end else if (rd_err) begin
        dout_q     <= '0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_src   = dout_src_q;
  assign dout_valid = dout_valid_q;
  assign error      = error_q;
  assign count      = count_q;
endmodule
